// File: rtl/mdio_sccb_bus_arbiter.sv
// mdio_sccb_bus_arbiter
//   Request/grant owner of the shared scl_mdc / sda_mdio pad pair. Requester 0 is the MAC MDIO
//   master, requester 1 is the camera SCCB master. After an owner lets go, both pads stay released
//   for GUARD_CYCLES clocks before anyone else can take the bus.
// Parameters
//   GUARD_CYCLES  released-pad gap after a grant ends (>= 1)
//   MAX_HOLD      max grant length in clocks, 0 = unlimited
//   FIRST_PRIO    winner of a simultaneous request after reset (0 = MAC, 1 = CAM)
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_mac/gnt_mac             MAC request level / ownership
//   mac_{scl,sda}_{o,oe}        MAC pad value and enable
//   req_cam/gnt_cam             camera request level / ownership
//   cam_{scl,sda}_{o,oe}        camera pad value and enable
//   pad_{scl,sda}_{o,oe}        to the top-level tristate buffers
//   owner                       00 none, 01 MAC, 10 CAM, 11 guard
//   hold_timeout                one-cycle pulse when MAX_HOLD revokes a grant
module mdio_sccb_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned MAX_HOLD     = 0,
  parameter int unsigned FIRST_PRIO   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_mac,
  output logic       gnt_mac,
  input  logic       mac_scl_o,
  input  logic       mac_scl_oe,
  input  logic       mac_sda_o,
  input  logic       mac_sda_oe,
  input  logic       req_cam,
  output logic       gnt_cam,
  input  logic       cam_scl_o,
  input  logic       cam_scl_oe,
  input  logic       cam_sda_o,
  input  logic       cam_sda_oe,
  output logic       pad_scl_o,
  output logic       pad_scl_oe,
  output logic       pad_sda_o,
  output logic       pad_sda_oe,
  output logic [1:0] owner,
  output logic       hold_timeout
);

  localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned HoldW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [GuardW-1:0] GuardLoad = GuardW'(GUARD_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldLast  = (MAX_HOLD > 0) ? HoldW'(MAX_HOLD - 1) : '0;

  // Encoding doubles as the owner code, so owner is a straight copy of the state register.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StOwnMac = 2'b01,
    StOwnCam = 2'b10,
    StGuard  = 2'b11
  } state_e;

  state_e            state_q;
  logic [GuardW-1:0] guard_cnt_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic              rr_q;         // 0: MAC wins a tie, 1: CAM wins a tie
  logic              blk_mac_q;    // revoked by timeout, waiting to see req low
  logic              blk_cam_q;

  logic elig_mac, elig_cam, hold_expired;

  assign elig_mac     = req_mac && !blk_mac_q;
  assign elig_cam     = req_cam && !blk_cam_q;
  assign hold_expired = (MAX_HOLD > 0) && (hold_cnt_q == HoldLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      guard_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      rr_q         <= 1'(FIRST_PRIO);
      blk_mac_q    <= 1'b0;
      blk_cam_q    <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      hold_timeout <= 1'b0;
      if (!req_mac) blk_mac_q <= 1'b0;
      if (!req_cam) blk_cam_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (elig_mac && (!elig_cam || !rr_q)) begin
            state_q    <= StOwnMac;
            hold_cnt_q <= '0;
            rr_q       <= 1'b1;
          end else if (elig_cam) begin
            state_q    <= StOwnCam;
            hold_cnt_q <= '0;
            rr_q       <= 1'b0;
          end
        end

        StOwnMac: begin
          if (!req_mac) begin
            state_q     <= StGuard;
            guard_cnt_q <= GuardLoad;
          end else if (hold_expired) begin
            state_q      <= StGuard;
            guard_cnt_q  <= GuardLoad;
            hold_timeout <= 1'b1;
            blk_mac_q    <= 1'b1;
          end else if (MAX_HOLD > 0) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        StOwnCam: begin
          if (!req_cam) begin
            state_q     <= StGuard;
            guard_cnt_q <= GuardLoad;
          end else if (hold_expired) begin
            state_q      <= StGuard;
            guard_cnt_q  <= GuardLoad;
            hold_timeout <= 1'b1;
            blk_cam_q    <= 1'b1;
          end else if (MAX_HOLD > 0) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        StGuard: begin
          if (guard_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            guard_cnt_q <= guard_cnt_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Grants and pad mux decode only the registered state, so reset releases the pads at once
  // and a non-owner can never leak onto the pads.
  assign gnt_mac = (state_q == StOwnMac);
  assign gnt_cam = (state_q == StOwnCam);
  assign owner   = state_q;

  always_comb begin
    pad_scl_o  = 1'b1;
    pad_scl_oe = 1'b0;
    pad_sda_o  = 1'b1;
    pad_sda_oe = 1'b0;
    unique case (state_q)
      StOwnMac: begin
        pad_scl_o  = mac_scl_o;
        pad_scl_oe = mac_scl_oe;
        pad_sda_o  = mac_sda_o;
        pad_sda_oe = mac_sda_oe;
      end
      StOwnCam: begin
        pad_scl_o  = cam_scl_o;
        pad_scl_oe = cam_scl_oe;
        pad_sda_o  = cam_sda_o;
        pad_sda_oe = cam_sda_oe;
      end
      default: ;
    endcase
  end

endmodule
